// File: rtl/sd_cmd_master.sv
// sd_cmd_master: SD command-path controller. It launches one command, waits for the serial host and checks the response.
// The optional command watchdog is enabled by defining SD_CMD_MASTER_TIMEOUT_EN.
module sd_cmd_master (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         int_status_rst_i,
  input  logic [31:0]  argument_i,
  input  logic [13:0]  command_i,
  input  logic [23:0]  timeout_i,
  input  logic [119:0] response_i,
  input  logic         crc_ok_i,
  input  logic         index_ok_i,
  input  logic         finish_i,
  input  logic         busy_i,
  output logic [1:0]   setting_o,
  output logic         start_xfr_o,
  output logic         go_idle_o,
  output logic [39:0]  cmd_o,
  output logic [4:0]   int_status_o,
  output logic [31:0]  response_0_o,
  output logic [31:0]  response_1_o,
  output logic [31:0]  response_2_o,
  output logic [31:0]  response_3_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EXECUTE    = 2'd1,
    ST_BUSY_CHECK = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_crc_chk;
  logic       r_idx_chk;
  logic       r_busy_chk;
  logic       w_load;
  logic       w_capture;
  logic       w_crc_err;
  logic       w_idx_err;
  logic       w_expire;
  logic [4:0] w_set;
  logic       w_unused;

  // Response checks only apply when the command expects a response.
  assign w_crc_err = setting_o[0] & r_crc_chk & ~crc_ok_i;
  assign w_idx_err = setting_o[0] & r_idx_chk & ~index_ok_i;

`ifdef SD_CMD_MASTER_TIMEOUT_EN
  logic [23:0] r_wdog;

  assign w_expire = (r_state == ST_EXECUTE) && (timeout_i != 24'd0) &&
                    ((r_wdog + 24'd1) == timeout_i);
  assign w_unused = ^command_i[7:5];

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= 24'd0;
      go_idle_o <= 1'b0;
    end else begin
      go_idle_o <= w_expire & ~finish_i;
      if (w_load)
        r_wdog <= 24'd0;
      else if (r_state == ST_EXECUTE)
        r_wdog <= r_wdog + 24'd1;
    end
  end
`else
  assign w_expire  = 1'b0;
  assign go_idle_o = 1'b0;
  assign w_unused  = ^{command_i[7:5], timeout_i};
`endif

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_set       = 5'd0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // finish_i takes priority over a watchdog expiry in the same cycle
        if (finish_i) begin
          w_capture = 1'b1;
          if (w_crc_err || w_idx_err) begin
            w_set       = {w_idx_err, w_crc_err, 1'b0, 1'b1, 1'b1};
            w_state_nxt = ST_IDLE;
          end else if (r_busy_chk) begin
            w_state_nxt = ST_BUSY_CHECK;
          end else begin
            w_set       = 5'b00001;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_expire) begin
          w_set       = 5'b00110;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_CHECK: begin
        if (!busy_i) begin
          w_set       = 5'b00001;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      start_xfr_o  <= 1'b0;
      cmd_o        <= 40'd0;
      setting_o    <= 2'd0;
      r_crc_chk    <= 1'b0;
      r_idx_chk    <= 1'b0;
      r_busy_chk   <= 1'b0;
      int_status_o <= 5'd0;
      response_0_o <= 32'd0;
      response_1_o <= 32'd0;
      response_2_o <= 32'd0;
      response_3_o <= 32'd0;
    end else begin
      start_xfr_o <= w_load;
      if (w_load) begin
        cmd_o        <= {2'b01, command_i[13:8], argument_i};
        setting_o    <= {(command_i[1:0] == 2'b10), (|command_i[1:0])};
        r_crc_chk    <= command_i[3];
        r_idx_chk    <= command_i[4];
        r_busy_chk   <= command_i[2];
        int_status_o <= 5'd0;
      end else begin
        // a status bit being set wins over a simultaneous clear request
        int_status_o <= (int_status_rst_i ? 5'd0 : int_status_o) | w_set;
      end
      if (w_capture) begin
        response_0_o <= response_i[119:88];
        response_1_o <= response_i[87:56];
        response_2_o <= response_i[55:24];
        response_3_o <= {response_i[23:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_master.sv
// Self-checking bench for sd_cmd_master: directed scenarios plus randomized commands against a behavioural model.
module tb_sd_cmd_master;
  logic         sd_clk = 1'b0;
  logic         rst, start_i, int_status_rst_i, crc_ok_i, index_ok_i, finish_i, busy_i;
  logic [31:0]  argument_i;
  logic [13:0]  command_i;
  logic [23:0]  timeout_i;
  logic [119:0] response_i;
  logic [1:0]   setting_o;
  logic         start_xfr_o, go_idle_o;
  logic [39:0]  cmd_o;
  logic [4:0]   int_status_o;
  logic [31:0]  response_0_o, response_1_o, response_2_o, response_3_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sd_clk = ~sd_clk;

  sd_cmd_master dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .int_status_rst_i(int_status_rst_i),
    .argument_i(argument_i), .command_i(command_i), .timeout_i(timeout_i),
    .response_i(response_i), .crc_ok_i(crc_ok_i), .index_ok_i(index_ok_i),
    .finish_i(finish_i), .busy_i(busy_i), .setting_o(setting_o),
    .start_xfr_o(start_xfr_o), .go_idle_o(go_idle_o), .cmd_o(cmd_o),
    .int_status_o(int_status_o), .response_0_o(response_0_o),
    .response_1_o(response_1_o), .response_2_o(response_2_o), .response_3_o(response_3_o)
  );

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic launch(input logic [13:0] cmd, input logic [31:0] arg, input logic [23:0] tmo);
    command_i  = cmd;
    argument_i = arg;
    timeout_i  = tmo;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic finish_now();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [232:0] outs;
    rst = 1'b0; start_i = 0; int_status_rst_i = 0; crc_ok_i = 1; index_ok_i = 1;
    finish_i = 0; busy_i = 0; argument_i = 0; command_i = 0; timeout_i = 0; response_i = 0;
    #2 rst = 1'b1;
    tick(); tick();
    outs = {setting_o, start_xfr_o, go_idle_o, cmd_o, int_status_o,
            response_0_o, response_1_o, response_2_o, response_3_o};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(14'h0000, 32'h0, 24'd0);
    n_checks++;
    if (start_xfr_o !== 1'b1) $display("FAIL basic_start_xfr: got %b want 1", start_xfr_o); else n_pass++;
    n_checks++;
    if (cmd_o !== 40'h4000000000) $display("FAIL basic_cmd: got %h want 4000000000", cmd_o); else n_pass++;
    tick();
    n_checks++;
    if (start_xfr_o !== 1'b0) $display("FAIL basic_strobe_len: got %b want 0", start_xfr_o); else n_pass++;
    finish_now();
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL basic_status: got %b want 00001", int_status_o); else n_pass++;
  endtask

  task automatic test_short_resp();
    crc_ok_i = 1; index_ok_i = 1; response_i = 120'hAB << 112;
    launch(14'h0819, 32'h1AA, 24'd0);
    n_checks++;
    if (cmd_o !== 40'h48000001AA) $display("FAIL short_cmd: got %h want 48000001aa", cmd_o); else n_pass++;
    n_checks++;
    if (setting_o !== 2'b01) $display("FAIL short_setting: got %b want 01", setting_o); else n_pass++;
    tick();
    finish_now();
    n_checks++;
    if (response_0_o !== 32'hAB000000) $display("FAIL short_resp0: got %h want ab000000", response_0_o); else n_pass++;
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL short_status: got %b want 00001", int_status_o); else n_pass++;
  endtask

  task automatic test_crc_err();
    crc_ok_i = 0; index_ok_i = 1; response_i = 120'h123456789ABCDEF0123456789ABCDE;
    launch(14'h0819, 32'h1AA, 24'd0);
    tick(); tick();
    finish_now();
    crc_ok_i = 1;
    n_checks++;
    if (int_status_o !== 5'b01011) $display("FAIL crc_status: got %b want 01011", int_status_o); else n_pass++;
    response_i = '1;
    tick(); tick();
    n_checks++;
    if ({response_0_o, response_1_o, response_2_o, response_3_o} !== 128'h123456789ABCDEF0123456789ABCDE00)
      $display("FAIL resp_hold: got %h%h%h%h want 123456789abcdef0123456789abcde00",
               response_0_o, response_1_o, response_2_o, response_3_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
`ifdef SD_CMD_MASTER_TIMEOUT_EN
    int cnt;
    cnt = 0;
    launch(14'h0000, 32'h0, 24'd10);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (go_idle_o === 1'b1) begin cnt = k; break; end
    end
    n_checks++;
    if (cnt != 10) $display("FAIL timeout_latency: got %0d want 10 cycles", cnt); else n_pass++;
    n_checks++;
    if (int_status_o !== 5'b00110) $display("FAIL timeout_status: got %b want 00110", int_status_o); else n_pass++;
    tick();
    n_checks++;
    if (go_idle_o !== 1'b0) $display("FAIL timeout_pulse_len: got %b want 0", go_idle_o); else n_pass++;
    launch(14'h0000, 32'h0, 24'd5);
    for (int k = 1; k <= 4; k++) tick();
    finish_now();
    n_checks++;
    if ({go_idle_o, int_status_o} !== 6'b000001) $display("FAIL finish_wins: got %b want 000001", {go_idle_o, int_status_o}); else n_pass++;
    tick();
    n_checks++;
    if (go_idle_o !== 1'b0) $display("FAIL finish_wins_idle: got %b want 0", go_idle_o); else n_pass++;
`else
    logic seen;
    seen = 1'b0;
    launch(14'h0000, 32'h0, 24'd3);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (go_idle_o !== 1'b0 || int_status_o !== 5'd0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL no_watchdog: got activity %b want 0", seen); else n_pass++;
    finish_now();
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL no_watchdog_status: got %b want 00001", int_status_o); else n_pass++;
`endif
  endtask

  task automatic test_busy();
    logic early;
    early = 1'b0;
    launch(14'h0705, 32'hCAFE, 24'd0);
    busy_i = 1'b1;
    finish_now();
    for (int k = 0; k < 20; k++) begin
      if (int_status_o !== 5'd0) early = 1'b1;
      tick();
    end
    n_checks++;
    if (early !== 1'b0 || int_status_o !== 5'd0) $display("FAIL busy_early_cc: got %b want 00000", int_status_o); else n_pass++;
    busy_i = 1'b0;
    tick();
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL busy_cc: got %b want 00001", int_status_o); else n_pass++;
    int_status_rst_i = 1'b1;
    tick();
    int_status_rst_i = 1'b0;
    n_checks++;
    if (int_status_o !== 5'd0) $display("FAIL status_clear: got %b want 00000", int_status_o); else n_pass++;
    launch(14'h0001, 32'h0, 24'd0);
    int_status_rst_i = 1'b1;
    finish_now();
    int_status_rst_i = 1'b0;
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL set_wins_clear: got %b want 00001", int_status_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [232:0] outs;
    response_i = 120'hFEED << 100;
    launch(14'h0819, 32'h55AA55AA, 24'd0);
    tick(); tick();
    rst = 1'b1;
    #2;
    outs = {setting_o, start_xfr_o, go_idle_o, cmd_o, int_status_o,
            response_0_o, response_1_o, response_2_o, response_3_o};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_mid_outputs: got %h want 0", outs); else n_pass++;
    rst = 1'b0;
    tick();
    crc_ok_i = 1; index_ok_i = 1;
    launch(14'h2A01, 32'h01234567, 24'd0);
    n_checks++;
    if ({start_xfr_o, cmd_o} !== {1'b1, 40'h6A01234567}) $display("FAIL reset_mid_restart: got %b %h want 1 6a01234567", start_xfr_o, cmd_o); else n_pass++;
    finish_now();
    n_checks++;
    if (int_status_o !== 5'b00001) $display("FAIL reset_mid_status: got %b want 00001", int_status_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0]  rnd, arg;
    logic [127:0] wide;
    logic [13:0]  cmd;
    logic         resp_exp, crc_err, idx_err, err;
    logic [4:0]   exp_status;
    logic [39:0]  exp_cmd;
    logic [127:0] exp_resp;
    logic         bad;
    int           dly, blen;
    for (int it = 0; it < 40; it++) begin
      rnd = $urandom; cmd = rnd[13:0];
      arg = $urandom;
      wide = {$urandom, $urandom, $urandom, $urandom};
      rnd = $urandom; crc_ok_i = rnd[0]; index_ok_i = rnd[1];
      dly = $urandom_range(0, 6); blen = $urandom_range(0, 5);
      resp_exp   = (cmd[1:0] != 2'b00);
      crc_err    = resp_exp && cmd[3] && !crc_ok_i;
      idx_err    = resp_exp && cmd[4] && !index_ok_i;
      err        = crc_err || idx_err;
      exp_status = err ? {idx_err, crc_err, 1'b0, 1'b1, 1'b1} : 5'b00001;
      exp_cmd    = {2'b01, cmd[13:8], arg};
      exp_resp   = {wide[119:0], 8'h00};
      launch(cmd, arg, 24'd0);
      n_checks++;
      if ({setting_o, cmd_o} !== {(cmd[1:0] == 2'b10), resp_exp, exp_cmd})
        $display("FAIL rand_launch[%0d]: got %b %h want %b%b %h", it, setting_o, cmd_o, (cmd[1:0] == 2'b10), resp_exp, exp_cmd);
      else n_pass++;
      bad = 1'b0;
      for (int d = 0; d < dly; d++) begin
        rnd = $urandom; start_i = rnd[0]; argument_i = $urandom;
        tick();
        if (start_xfr_o !== 1'b0 || cmd_o !== exp_cmd) bad = 1'b1;
      end
      start_i = 1'b0;
      n_checks++;
      if (bad !== 1'b0) $display("FAIL rand_ignore_start[%0d]: got cmd %h want %h", it, cmd_o, exp_cmd); else n_pass++;
      response_i = wide[119:0];
      busy_i = (blen > 0);
      finish_now();
      if (!err && cmd[2]) begin
        bad = 1'b0;
        for (int b = 0; b < blen; b++) begin
          if (int_status_o !== 5'd0) bad = 1'b1;
          tick();
        end
        if (int_status_o !== 5'd0) bad = 1'b1;
        busy_i = 1'b0;
        tick();
        n_checks++;
        if (bad !== 1'b0) $display("FAIL rand_busy_wait[%0d]: got early status want 00000", it); else n_pass++;
      end
      busy_i = 1'b0;
      n_checks++;
      if (int_status_o !== exp_status) $display("FAIL rand_status[%0d]: got %b want %b", it, int_status_o, exp_status); else n_pass++;
      n_checks++;
      if ({response_0_o, response_1_o, response_2_o, response_3_o} !== exp_resp)
        $display("FAIL rand_resp[%0d]: got %h%h%h%h want %h", it, response_0_o, response_1_o, response_2_o, response_3_o, exp_resp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_resp();
    test_crc_err();
    test_timeout();
    test_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_master.md
SD_CMD_MASTER -- requirements
Module: sd_cmd_master

Interface
REQ-001 Parameters: none; widths fixed: command 14, timeout 24, status 5.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 sd_clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  async active-high reset.
REQ-005 start_i  in  1  launch one command; sampled only in IDLE.
REQ-006 int_status_rst_i  in  1  clear int_status_o.
REQ-007 argument_i  in  32  command argument.
REQ-008 command_i  in  14  [13:8] index; [4] index-check enable; [3] CRC-check enable; [2] busy-check enable; [1:0] response type (00 none, 01 short, 10 long, 11 short).
REQ-009 timeout_i  in  24  watchdog limit in sd_clk cycles; 0 disables.
REQ-010 response_i  in  120  response bits from the serial host.
REQ-011 crc_ok_i, index_ok_i, finish_i, busy_i  in  1 each  serial host CRC ok, index ok, transfer done; DAT0 busy.
REQ-012 setting_o  out  2  [0] response expected, [1] long response.
REQ-013 start_xfr_o  out  1  one-cycle start strobe to the serial host.
REQ-014 go_idle_o  out  1  one-cycle abort strobe to the serial host.
REQ-015 cmd_o  out  40  {2'b01, index[5:0], argument[31:0]}.
REQ-016 int_status_o  out  5  [0] CC complete, [1] EI error, [2] CTE timeout, [3] CCRC CRC error, [4] CIE index error.
REQ-017 response_0_o..response_3_o  out  32 each  captured response words.

Function
REQ-018 FSM states: IDLE, EXECUTE, BUSY_CHECK.
REQ-019 IDLE with start_i=1: next edge loads cmd_o and setting_o, asserts start_xfr_o for exactly 1 cycle, clears int_status_o and the watchdog, and enters EXECUTE.
REQ-020 setting_o[0] = |command_i[1:0]; setting_o[1] = (command_i[1:0]==2'b10).
REQ-021 start_i outside IDLE is ignored.
REQ-022 EXECUTE: watchdog increments each cycle; when timeout_i!=0 and watchdog reaches timeout_i before finish_i, set CTE and EI, pulse go_idle_o for 1 cycle, and return to IDLE.
REQ-023 EXECUTE with finish_i=1: capture response_0_o=response_i[119:88], response_1_o=[87:56], response_2_o=[55:24], response_3_o={response_i[23:0],8'h00}.
REQ-024 On finish, when a response is expected: CRC check enabled and !crc_ok_i sets CCRC and EI; index check enabled and !index_ok_i sets CIE and EI.
REQ-025 On finish with an error: set CC and go to IDLE.
REQ-026 On finish with no error: busy check enabled goes to BUSY_CHECK, otherwise set CC and go to IDLE.
REQ-027 BUSY_CHECK: stay while busy_i=1; at the first cycle with busy_i=0, set CC and go to IDLE; the watchdog is not applied in this state.
REQ-028 finish_i and watchdog expiry in the same cycle: finish wins, no timeout.
REQ-029 int_status_o bits are sticky until int_status_rst_i or a new start. Same-cycle set and int_status_rst_i: the set wins.
REQ-030 Response registers hold their value until the next finish.

Reset
REQ-031 rst=1 forces IDLE immediately, including mid-command.
REQ-032 Under reset all outputs are 0, including cmd_o, setting_o, int_status_o, response_*_o and the strobes; the watchdog is also 0.

Configuration
REQ-033 Macro SD_CMD_MASTER_TIMEOUT_EN.
- Defined: watchdog per REQ-022.
- Undefined: no watchdog logic; EXECUTE waits on finish_i indefinitely; CTE stays 0; go_idle_o is tied 0; timeout_i is ignored.

Verification
REQ-034 rst pulse, command_i=0, argument=0, start_i 1 cycle -> start_xfr_o 1 cycle; cmd_o=40'h4000000000; finish_i -> int_status_o=5'b00001.
REQ-035 command_i index=8, type 01, CRC and index checks on, argument=32'h1AA, finish with crc_ok=1, index_ok=1, response_i=120'hAB<<112 -> cmd_o=40'h48000001AA; response_0_o=32'hAB000000; status=00001.
REQ-036 Same command, finish with crc_ok=0 -> status=5'b01011.
REQ-037 timeout_i=10, finish never arrives -> go_idle_o 1 cycle ~10 cycles after start; status=5'b00110 (macro defined).
REQ-038 Busy check on, busy_i=1 for 20 cycles after finish -> CC only after busy_i falls; int_status_rst_i then clears status to 0.
REQ-039 rst asserted mid-EXECUTE -> all outputs 0 at once; new start works normally afterwards.
